issue_queue: RTL
================

Name: issue_queue

Overview:
- Dual-push, dual-pop circular FIFO of ISSUE_QUEUE_ELEMENT entries.
- Sits directly upstream of the issue stage. Decode/rename pushes up to 2 instructions per cycle.
- The queue presents its two oldest entries plus its occupancy to issue. Issue returns how many it consumed (iq_pop_number), and those are retired from the head at the clock edge.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), pointer width; IQ_ADDR must be ≥ PTR_W+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- flush  in  1  synchronous pipeline flush; empties queue.
- push_ena  in  2  per-slot push request from decode.
- push_data  in  ISSUE_QUEUE_ELEMENT[1:0]  entries to push; slot 0 is older.
- push_ready  out  1  queue can accept a 2-entry push this cycle.
- issue_require  out  ISSUE_QUEUE_ELEMENT[1:0]  [0] = head (oldest), [1] = head+1.
- iq_size  out  IQ_ADDR  current occupancy, 0..DEPTH.
- iq_pop_number  in  2  entries consumed by issue this cycle (0, 1 or 2).

Behaviour:
- State: storage array[DEPTH], head ptr, tail ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (rst=0, asynchronous): head=0, tail=0, count=0. Storage contents are don't-care.
- Outputs during and after reset: push_ready=1, iq_size=0, issue_require=0.
- push_ready = (DEPTH − count) ≥ 2:
  - Registered state only; no combinational path from push_ena or iq_pop_number.
  - Conservative: space freed by a same-cycle pop is not counted.
- Push accepted only when push_ready=1. push_ena with push_ready=0 is ignored; no partial accept.
- Push compaction:
  - Enabled slots are written in slot order starting at tail.
  - push_ena=2'b10 writes push_data[1] at tail.
  - push_ena=2'b11 writes [0] at tail and [1] at tail+1.
  - num_push = popcount(push_ena) when accepted, else 0.
- Pop:
  - eff_pop = min(iq_pop_number, count); iq_pop_number=3 is treated as 2 before clamping.
  - head advances by eff_pop modulo DEPTH.
- Same-cycle push and pop are both applied: count_next = count + num_push − eff_pop.
  - A pop never sees a same-cycle push; an entry is visible one cycle after it is pushed.
- issue_require:
  - Combinational read of storage[head] and storage[head+1 mod DEPTH].
  - Slot i is driven to all-zero when i ≥ count, so count=0 → both zero and count=1 → slot 1 zero.
- iq_size = count, registered.
- Latency: push at edge N is visible on issue_require/iq_size after edge N. Pop takes effect at the same edge.
- Wrap-around: pointers wrap DEPTH−1 → 0. head+1 read wraps the same way.
- Full: count=DEPTH means push_ready=0 and no write. count=DEPTH−1 also gives push_ready=0.
- flush=1 (synchronous, highest priority after rst): head=tail=count=0 next cycle. Same-cycle push and pop are discarded.
- rst asserted mid-operation: immediate clear. Any in-flight push is lost.

Optional Feature:
- Macro IQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_count (32 bits).
  - Increments when |push_ena && !push_ready && !flush; saturates at 32'hFFFF_FFFF.
  - Cleared by rst. Not cleared by flush.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - rst=0 for 2 cycles, release → iq_size=0, push_ready=1, issue_require both zero.
  - Pop 2 while empty → iq_size stays 0.
- Dual push then partial pop:
  - push_ena=2'b11 with A, B → next cycle iq_size=2, issue_require={B,A}.
  - iq_pop_number=1 → next cycle iq_size=1, [0]=B, [1]=0.
- Sparse slot push: push_ena=2'b10 with C in slot 1 on empty queue → iq_size=1, issue_require[0]=C.
- Fill and full (DEPTH=16):
  - Push pairs until count=14 → push_ready=1. One more pair → count=16, push_ready=0.
  - Further push_ena=2'b11 → count stays 16 and contents unchanged.
  - With IQ_STALL_CNT_EN, stall_count increments by 1 per such cycle.
- Simultaneous push/pop across wrap:
  - head=15, count=2: push 2 and pop 2 in the same cycle → count=2, head=1.
  - Entries read back in push order across index 15→0.
- Flush and async reset mid-stream:
  - count=5, flush=1 with push_ena=2'b11 → next cycle count=0.
  - Later, with count=3, assert rst between clock edges → iq_size=0 immediately, before the next edge.

Source files
------------

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - dual-push, dual-pop circular issue queue
//
// Purpose: buffers decoded/renamed instructions ahead of the issue stage.
//   Up to two entries are pushed per cycle and compacted in slot order.
//   The two oldest entries and the occupancy are presented to issue.
//   Issue consumes up to two entries per cycle by reporting iq_pop_number.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   flush          synchronous flush, empties the queue
//   push_ena       per-slot push request (slot 0 is older)
//   push_data      {slot1, slot0} entries, ELEM_W bits each
//   push_ready     queue can take a 2-entry push this cycle
//   issue_require  {head+1, head} entries, zero where unoccupied
//   iq_size        current occupancy, 0..DEPTH
//   iq_pop_number  entries consumed by issue this cycle (3 acts as 2)
//   stall_count    (IQ_STALL_CNT_EN only) saturating count of refused pushes
//
// Optional feature macro: IQ_STALL_CNT_EN
module issue_queue #(
   parameter int DEPTH   = 16,
   parameter int ELEM_W  = 32,
   parameter int PTR_W   = $clog2(DEPTH),
   parameter int IQ_ADDR = PTR_W + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [1:0]          push_ena,
   input  logic [2*ELEM_W-1:0] push_data,
   output logic                push_ready,
   output logic [2*ELEM_W-1:0] issue_require,
   output logic [IQ_ADDR-1:0]  iq_size,
   input  logic [1:0]          iq_pop_number
`ifdef IQ_STALL_CNT_EN
   ,
   output logic [31:0]         stall_count
`endif
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

   logic [ELEM_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              push_acc;
   logic [CNT_W-1:0]  num_push;
   logic [CNT_W-1:0]  pop_req;
   logic [CNT_W-1:0]  eff_pop;
   logic [ELEM_W-1:0] data0;
   logic [ELEM_W-1:0] data1;
   logic [ELEM_W-1:0] first_wr;
   logic [PTR_W-1:0]  head_p1;

   assign data0   = push_data[ELEM_W-1:0];
   assign data1   = push_data[2*ELEM_W-1:ELEM_W];
   assign head_p1 = head + PTR_W'(1);

   always_comb begin
      // Only registered occupancy decides readiness; space freed by a
      // same-cycle pop is deliberately ignored to keep this path short.
      push_ready = (count <= READY_MAX);
      push_acc   = push_ready && (push_ena != 2'b00);
      num_push   = '0;
      if (push_acc) begin
         num_push = CNT_W'(push_ena[0]) + CNT_W'(push_ena[1]);
      end
      pop_req = (iq_pop_number == 2'd3) ? CNT_W'(2) : CNT_W'(iq_pop_number);
      eff_pop = (pop_req > count) ? count : pop_req;
      // Compaction: the lowest enabled slot always lands at tail.
      first_wr = push_ena[0] ? data0 : data1;
   end

   // Storage needs no reset; occupancy gates everything that reads it.
   always_ff @(posedge clk) begin
      if (push_acc && !flush) begin
         mem[tail] <= first_wr;
         if (push_ena == 2'b11) begin
            mem[tail + PTR_W'(1)] <= data1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(eff_pop);
         tail  <= tail + PTR_W'(num_push);
         count <= count + num_push - eff_pop;
      end
   end

   always_comb begin
      issue_require = '0;
      if (count != '0) begin
         issue_require[ELEM_W-1:0] = mem[head];
      end
      if (count >= CNT_W'(2)) begin
         issue_require[2*ELEM_W-1:ELEM_W] = mem[head_p1];
      end
   end

   assign iq_size = IQ_ADDR'(count);

`ifdef IQ_STALL_CNT_EN
   // Survives flush so stall statistics span pipeline restarts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if ((push_ena != 2'b00) && !push_ready && !flush &&
                   (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
